id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register for the 16-bit pipelined MIPS datapath; sits directly downstream of the 4->16 immediate sign extender.

---
 rtl/id_ex_pipe_reg_pkg.sv | 37 +++
 rtl/id_ex_pipe_reg_load_use_hazard_unit.sv | 31 +++
 rtl/id_ex_pipe_reg.sv | 130 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg: shared widths, ALU op encodings and control-bundle type for the ID/EX stage
package id_ex_pipe_reg_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_REG_AW  = 4;
  localparam int DEF_ALUOP_W = 3;
  localparam int CTRL_W      = 6;

  // R0 is hardwired to zero, so it never carries a real load result
  localparam logic [DEF_REG_AW-1:0] ZERO_REG = 4'd0;

  typedef enum logic [DEF_ALUOP_W-1:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_SRL  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  // Bubbles and invalid slots must carry all-zero control, not just valid=0
  function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic en);
    return en ? c : '0;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_load_use_hazard_unit.sv
// load_use_hazard_unit: detects a load in EX whose destination is read by the instruction in ID
module load_use_hazard_unit
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_addr_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic              id_uses_rt_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              hz_o,
  output logic              stall_o
);

  logic rs_match;
  logic rt_match;

  // rt only counts as a dependency when the ID instruction actually reads it
  always_comb begin
    rs_match = ex_rt_addr_i == id_rs_addr_i;
    rt_match = id_uses_rt_i & (ex_rt_addr_i == id_rt_addr_i);
    hz_o     = ex_valid_i & ex_mem_read_i & (ex_rt_addr_i != '0) & (rs_match | rt_match) & id_valid_i;
    stall_o  = hz_o & ~flush_i & ~hold_i;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with load-use bubble insertion, hold and branch flush
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int ALUOP_W = DEF_ALUOP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic [DATA_W-1:0]  id_rs_data_i,
  input  logic [DATA_W-1:0]  id_rt_data_i,
  input  logic [DATA_W-1:0]  id_imm16_i,
  input  logic [REG_AW-1:0]  id_rs_addr_i,
  input  logic [REG_AW-1:0]  id_rt_addr_i,
  input  logic [REG_AW-1:0]  id_rd_addr_i,
  input  logic               id_uses_rt_i,
  input  logic               id_reg_write_i,
  input  logic               id_mem_read_i,
  input  logic               id_mem_write_i,
  input  logic               id_mem_to_reg_i,
  input  logic               id_alu_src_i,
  input  logic               id_reg_dst_i,
  input  logic [ALUOP_W-1:0] id_alu_op_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [DATA_W-1:0]  ex_rs_data_o,
  output logic [DATA_W-1:0]  ex_rt_data_o,
  output logic [DATA_W-1:0]  ex_imm16_o,
  output logic [REG_AW-1:0]  ex_rs_addr_o,
  output logic [REG_AW-1:0]  ex_rt_addr_o,
  output logic [REG_AW-1:0]  ex_rd_addr_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic               ex_mem_write_o,
  output logic               ex_mem_to_reg_o,
  output logic               ex_alu_src_o,
  output logic               ex_reg_dst_o,
  output logic [ALUOP_W-1:0] ex_alu_op_o
);

  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d;
  logic [DATA_W-1:0]  rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm16_q, imm16_d;
  logic [REG_AW-1:0]  rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0]  rt_addr_q, rt_addr_d;
  logic [REG_AW-1:0]  rd_addr_q, rd_addr_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  ctrl_t              ctrl_q, ctrl_d, id_ctrl;
  logic               hz;
  logic               bubble;
  logic               ctl_en;

  load_use_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_addr_i  (rt_addr_q),
    .id_valid_i    (id_valid_i),
    .id_rs_addr_i  (id_rs_addr_i),
    .id_rt_addr_i  (id_rt_addr_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .flush_i       (flush_i),
    .hold_i        (hold_i),
    .hz_o          (hz),
    .stall_o       (stall_o)
  );

  assign id_ctrl = {id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i, id_alu_src_i, id_reg_dst_i};
  // Flush and hazard both load an all-zero bubble; hold outranks both at the register
  assign bubble  = flush_i | hz;
  assign ctl_en  = ~bubble & id_valid_i;

  // Next state: hold keeps everything, a bubble zeroes everything, otherwise capture ID
  always_comb begin
    valid_d   = hold_i ? valid_q   : ctl_en;
    rs_data_d = hold_i ? rs_data_q : bubble ? '0 : id_rs_data_i;
    rt_data_d = hold_i ? rt_data_q : bubble ? '0 : id_rt_data_i;
    imm16_d   = hold_i ? imm16_q   : bubble ? '0 : id_imm16_i;
    rs_addr_d = hold_i ? rs_addr_q : bubble ? '0 : id_rs_addr_i;
    rt_addr_d = hold_i ? rt_addr_q : bubble ? '0 : id_rt_addr_i;
    rd_addr_d = hold_i ? rd_addr_q : bubble ? '0 : id_rd_addr_i;
    ctrl_d    = hold_i ? ctrl_q    : ctrl_gate(id_ctrl, ctl_en);
    alu_op_d  = hold_i ? alu_op_q  : ctl_en ? id_alu_op_i : '0;
  end

  // Pipeline register; async reset leaves a bubble in EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm16_q   <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      ctrl_q    <= '0;
      alu_op_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm16_q   <= imm16_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
    end
  end

  assign ex_valid_o      = valid_q;
  assign ex_rs_data_o    = rs_data_q;
  assign ex_rt_data_o    = rt_data_q;
  assign ex_imm16_o      = imm16_q;
  assign ex_rs_addr_o    = rs_addr_q;
  assign ex_rt_addr_o    = rt_addr_q;
  assign ex_rd_addr_o    = rd_addr_q;
  assign ex_reg_write_o  = ctrl_q.reg_write;
  assign ex_mem_read_o   = ctrl_q.mem_read;
  assign ex_mem_write_o  = ctrl_q.mem_write;
  assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;
  assign ex_alu_src_o    = ctrl_q.alu_src;
  assign ex_reg_dst_o    = ctrl_q.reg_dst;
  assign ex_alu_op_o     = alu_op_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: scoreboard bench for the ID/EX pipeline register and its load-use stall
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm16;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [3:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  alu_op;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic flush = 1'b0;
  logic uses_rt = 1'b0;
  ex_t  id = '0;
  ex_t  obs;
  ex_t  m = '0;
  ex_t  sbq[$];
  logic stall;
  int   checks = 0;
  int   errors = 0;

  logic        ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_rd_dst;
  logic [15:0] ex_rsd, ex_rtd, ex_imm;
  logic [3:0]  ex_rsa, ex_rta, ex_rda;
  logic [2:0]  ex_op;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hold_i          (hold),
    .flush_i         (flush),
    .id_valid_i      (id.valid),
    .id_rs_data_i    (id.rs_data),
    .id_rt_data_i    (id.rt_data),
    .id_imm16_i      (id.imm16),
    .id_rs_addr_i    (id.rs_addr),
    .id_rt_addr_i    (id.rt_addr),
    .id_rd_addr_i    (id.rd_addr),
    .id_uses_rt_i    (uses_rt),
    .id_reg_write_i  (id.reg_write),
    .id_mem_read_i   (id.mem_read),
    .id_mem_write_i  (id.mem_write),
    .id_mem_to_reg_i (id.mem_to_reg),
    .id_alu_src_i    (id.alu_src),
    .id_reg_dst_i    (id.reg_dst),
    .id_alu_op_i     (id.alu_op),
    .stall_o         (stall),
    .ex_valid_o      (ex_valid),
    .ex_rs_data_o    (ex_rsd),
    .ex_rt_data_o    (ex_rtd),
    .ex_imm16_o      (ex_imm),
    .ex_rs_addr_o    (ex_rsa),
    .ex_rt_addr_o    (ex_rta),
    .ex_rd_addr_o    (ex_rda),
    .ex_reg_write_o  (ex_rw),
    .ex_mem_read_o   (ex_mr),
    .ex_mem_write_o  (ex_mw),
    .ex_mem_to_reg_o (ex_m2r),
    .ex_alu_src_o    (ex_as),
    .ex_reg_dst_o    (ex_rd_dst),
    .ex_alu_op_o     (ex_op)
  );

  assign obs = {ex_valid, ex_rsd, ex_rtd, ex_imm, ex_rsa, ex_rta, ex_rda,
                ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_rd_dst, ex_op};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_hz(input ex_t e, input ex_t d, input logic u);
    return e.valid && e.mem_read && e.rt_addr != 4'd0 && d.valid &&
           (e.rt_addr == d.rs_addr || (u && e.rt_addr == d.rt_addr));
  endfunction

  function automatic ex_t model_next(input ex_t e, input ex_t d, input logic u, input logic h, input logic f);
    ex_t n;
    if (h) return e;
    if (f || model_hz(e, d, u)) return '0;
    n = d;
    if (!d.valid) begin
      n.reg_write = 0; n.mem_read = 0; n.mem_write = 0;
      n.mem_to_reg = 0; n.alu_src = 0; n.reg_dst = 0; n.alu_op = 0;
    end
    return n;
  endfunction

  // Checks the combinational stall, pushes the expected EX slot, then pops it after the edge
  task automatic step(input string tag);
    #1;
    check({tag, "_stall"}, stall, model_hz(m, id, uses_rt) & ~flush & ~hold);
    m = model_next(m, id, uses_rt, hold, flush);
    sbq.push_back(m);
    @(posedge clk);
    #1;
    check({tag, "_ex"}, obs, sbq.pop_front());
  endtask

  task automatic lw(input logic [3:0] rs, input logic [3:0] rt);
    id = '0; uses_rt = 0; hold = 0; flush = 0;
    id.valid = 1; id.rs_addr = rs; id.rt_addr = rt; id.imm16 = 16'h0004;
    id.rs_data = 16'h1000; id.mem_read = 1; id.reg_write = 1; id.mem_to_reg = 1; id.alu_src = 1;
  endtask

  task automatic add(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd, input logic u);
    id = '0; uses_rt = u; hold = 0; flush = 0;
    id.valid = 1; id.rs_addr = rs; id.rt_addr = rt; id.rd_addr = rd;
    id.rs_data = 16'hA5A5; id.rt_data = 16'h0F0F; id.reg_write = 1; id.reg_dst = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ex", obs, 0);
    check("reset_stall", stall, 0);
    rst_n = 1;
    // Pass-through of a sign-extended immediate
    id = '0; id.valid = 1; id.rs_addr = 3; id.rs_data = 16'h1234; id.rt_addr = 2; id.rt_data = 16'h5555;
    id.rd_addr = 7; id.imm16 = 16'hFFF9; id.alu_op = 3'd2; id.reg_write = 1; id.alu_src = 1;
    step("pass");
    check("pass_imm", ex_imm, 16'hFFF9);
    // Load-use: one bubble, then the same add is captured
    lw(1, 5); step("lu_lw");
    add(5, 6, 7, 1); step("lu_bubble");
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rw", ex_rw, 0);
    step("lu_retry");
    check("lu_retry_valid", ex_valid, 1);
    // No false hazard on R0 or on an rt that is only a destination
    lw(2, 0); step("r0_lw");
    add(0, 0, 3, 1); step("r0_add");
    lw(2, 4); step("ld1");
    lw(1, 4); step("ld2_indep");
    add(4, 1, 3, 0); step("ld2_dep");
    step("ld2_dep_retry");
    // Flush beats the hazard and the ID instruction is not repeated
    lw(1, 5); step("fl_lw");
    add(5, 6, 7, 1); flush = 1; step("fl_flush");
    add(8, 9, 10, 1); step("fl_next");
    // Hold freezes state while ID keeps changing
    for (int i = 0; i < 3; i++) begin
      add(4'(i + 1), 4'(i + 2), 4'(i + 3), 1); id.rs_data = 16'($urandom); hold = 1; step("hold");
    end
    lw(1, 5); step("hh_lw");
    add(5, 6, 7, 1); hold = 1; step("hh_hold");
    hold = 0; step("hh_release");
    step("hh_retry");
    // Randomised traffic with occasional hold and flush
    for (int i = 0; i < 60; i++) begin
      id = ex_t'({$urandom, $urandom, $urandom});
      id.rs_addr = 4'($urandom_range(0, 3)); id.rt_addr = 4'($urandom_range(0, 3));
      uses_rt = 1'($urandom); hold = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    // Reset asserted mid-stall clears outputs and stall without a clock edge
    lw(1, 5); step("rs_lw");
    add(5, 6, 7, 1);
    #1;
    check("rs_pre_stall", stall, 1);
    rst_n = 0;
    #1;
    check("rs_mid_ex", obs, 0);
    check("rs_mid_stall", stall, 0);
    m = '0;
    @(posedge clk);
    #1;
    rst_n = 1;
    add(3, 4, 5, 1); step("rs_after");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
